// File: rtl/sound_pad_pkg.sv
// Shared definitions for the sound pad: matrix geometry, the key-code type
// and the lowest-index priority encoder.
package sound_pad_pkg;

    localparam int ROWS     = 4;
    localparam int COLS     = 3;
    localparam int NUM_KEYS = ROWS * COLS;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_NONE = 4'hF;

    // The lowest set index wins, so a lower key masks any higher keys held with it.
    function automatic key_code_t lowest_key(input logic [NUM_KEYS-1:0] keys);
        key_code_t code;
        code = KEY_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) begin
                code = key_code_t'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/pad_debouncer.sv
// Frame-level debouncer: a new 12-key frame is accepted only after it has been
// seen in DEBOUNCE_SCANS consecutive complete frames.
module pad_debouncer
    import sound_pad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] frame,
    input  logic                frame_done,
    output logic [NUM_KEYS-1:0] deb
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [NUM_KEYS-1:0] cand_reg, cand_next;
    logic [NUM_KEYS-1:0] deb_reg, deb_next;
    logic [CNT_W-1:0]    stable_cnt_reg, stable_cnt_next;

    always_comb begin
        cand_next       = cand_reg;
        stable_cnt_next = stable_cnt_reg;
        deb_next        = deb_reg;
        if (frame_done) begin
            if (frame == cand_reg) begin
                if (stable_cnt_reg != CNT_MAX) begin
                    stable_cnt_next = stable_cnt_reg + 1'b1;
                end
            end else begin
                cand_next       = frame;
                stable_cnt_next = CNT_W'(1);
            end
            // Judged on the updated count so acceptance lands on this frame's edge.
            if (stable_cnt_next == CNT_MAX) begin
                deb_next = cand_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_reg       <= '0;
            stable_cnt_reg <= '0;
            deb_reg        <= '0;
        end else begin
            cand_reg       <= cand_next;
            stable_cnt_reg <= stable_cnt_next;
            deb_reg        <= deb_next;
        end
    end

    assign deb = deb_reg;

endmodule

// File: rtl/pad_scanner.sv
// Keypad front end: scans the 4x3 pad matrix row by row, debounces whole
// frames and resolves the result to one key code with a press-event strobe.
module pad_scanner
    import sound_pad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:COLS-1]   pad,
    output logic [0:ROWS-1]   pad_pos_out,
    output key_code_t         key_code,
    output logic              key_hold,
    output logic              key_event
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]    div_cnt_reg;
    logic [1:0]          row_reg;
    logic [NUM_KEYS-1:0] raw_reg, raw_next;
    logic [NUM_KEYS-1:0] deb;
    key_code_t           key_code_reg, key_code_next;
    logic                key_event_reg;
    logic                dwell_end, frame_done;

    // Sample at the end of the dwell, when the row select has had time to settle.
    assign dwell_end  = (div_cnt_reg == DIV_LAST);
    assign frame_done = dwell_end && (row_reg == 2'd3);

    // The debouncer sees the frame including the row-3 bits sampled this edge.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_raw
            assign raw_next[gi] = (dwell_end && row_reg == 2'(gi / COLS))
                                ? pad[gi % COLS] : raw_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            row_reg     <= '0;
            raw_reg     <= '0;
        end else if (dwell_end) begin
            div_cnt_reg <= '0;
            row_reg     <= row_reg + 2'd1;
            raw_reg     <= raw_next;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    pad_debouncer #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debouncer (
        .clk        (clk),
        .rst        (rst),
        .frame      (raw_next),
        .frame_done (frame_done),
        .deb        (deb)
    );

    assign key_code_next = lowest_key(deb);

    // Key-to-key changes strobe too; only a release to KEY_NONE stays silent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code_reg  <= KEY_NONE;
            key_event_reg <= 1'b0;
        end else begin
            key_code_reg  <= key_code_next;
            key_event_reg <= (key_code_next != key_code_reg) && (key_code_next != KEY_NONE);
        end
    end

    assign pad_pos_out = 4'b1000 >> row_reg;
    assign key_code    = key_code_reg;
    assign key_hold    = (key_code_reg != KEY_NONE);
    assign key_event   = key_event_reg;

endmodule

// File: doc/pad_scanner.md
# pad_scanner

Keypad front end for the sound pad. Drives the 4-row one-hot select onto the 4×3 pad matrix and samples the 3 column lines. Debounces all 12 switches over whole scan frames. Resolves the debounced state to a single key code with a press-event strobe for the tone stage downstream.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row stays selected; legal range ≥ 2.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full frames needed to accept a new pad state; legal range ≥ 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pad`  in  [0:2]  column sense lines; bit c = 1 when the key in the selected row, column c is pressed.
- `pad_pos_out`  out  [0:3]  one-hot row select; bit r = 1 selects row r.
- `key_code`  out  [3:0]  resolved key index `row*3+col` (0..11); 4'hF when no key is held.
- `key_hold`  out  1  high while `key_code` ≠ 4'hF.
- `key_event`  out  1  one-cycle pulse when a new key becomes the resolved key.

## Operation
- **Row scan.**
  - `div_cnt` counts 0..SCAN_DIV-1, then wraps to 0. On each wrap, `row` advances 0→1→2→3→0.
  - `pad_pos_out` = 4'b1000 >> `row`, so row 0 gives 1000 and row 3 gives 0001.
- **Sampling.**
  - Sampling happens on the edge where `div_cnt` = SCAN_DIV-1, which is the settled end of the row dwell.
  - `pad[c]` is written to `raw[row*3+c]` (12-bit raw frame).
  - The sample taken with `row` = 3 completes a frame (`frame_done`).
- **Debounce**, evaluated on `frame_done`, using the completed frame including the row-3 bits just sampled:
  - If the frame equals `cand`: `stable_cnt` increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: `cand` ← frame and `stable_cnt` ← 1.
  - When the updated `stable_cnt` equals DEBOUNCE_SCANS: `deb` ← `cand`.
- **Resolution**, registered one cycle after `deb` updates:
  - The lowest set bit index of `deb` wins, so with several keys held the lower index takes priority.
  - If `deb` = 0: `key_code` = 4'hF and `key_hold` = 0.
- **Event.** `key_event` = 1 for exactly one cycle when the registered `key_code` changes to a value ≠ 4'hF.
  - This covers a change from none to a key and a direct change from key A to key B.
  - Release (change to 4'hF) produces no event.
- **Reset values.**
  - `row` = 0, so `pad_pos_out` = 4'b1000.
  - `div_cnt`, `raw`, `cand`, `stable_cnt` and `deb` are all 0.
  - `key_code` = 4'hF, `key_hold` = 0, `key_event` = 0.
- **Reset mid-scan.** Reset aborts the partial frame and discards the debounce progress. Scanning restarts at row 0 the first edge after reset deasserts.

## Timing
- A full frame takes 4·SCAN_DIV cycles.
- **Press latency.** A press that is stable across DEBOUNCE_SCANS complete frames gives:
  - `deb` updated on the frame_done edge of the last of those frames;
  - `key_code`/`key_hold`/`key_event` updated on the following edge.
- **Partial frames.** A press that begins mid-frame counts only from the first frame in which it is sampled. Worst-case latency is (DEBOUNCE_SCANS+1)·4·SCAN_DIV + 1 cycles.
- **Bounce.** Any frame that differs from `cand` restarts the count at 1. A key bouncing faster than one frame is never accepted.
- **Release.** Release follows the same rule: the all-zero frame must repeat DEBOUNCE_SCANS times.
- **Timing of `pad`.** `pad` is treated as synchronous to the row select of the same dwell. The block does not synchronise `pad`; the top level places a 2-flop synchroniser ahead of this block.

## Structure
- **Shared package `sound_pad_pkg`:**
  - `ROWS` = 4, `COLS` = 3, `NUM_KEYS` = 12;
  - `KEY_NONE` = 4'hF;
  - the key-code type (4-bit), used by this block and the tone stage.
- **Sub-module `pad_debouncer`:**
  - inputs: 12-bit frame, `frame_done`;
  - output: 12-bit `deb`;
  - contains `cand` and `stable_cnt`, parameterised by DEBOUNCE_SCANS.
- **Top:** row/divider counters, sampling, priority encoder and event logic.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2 (16-cycle frame), with the bench driving `pad` from `pad_pos_out`.
- **Reset:** `rst` held, then released → `pad_pos_out` = 1000, `key_code` = F, `key_hold` = 0. Rows step 1000, 0100, 0010, 0001, each for 4 cycles, then wrap.
- **Single key:** key 0 held from reset (pad=100 when row 0 is selected, else 000).
  - `key_code` = 0 and `key_hold` = 1 on the edge after the 2nd frame_done (cycle 33).
  - `key_event` pulses once at that same edge.
- **Key change:** key 0 → key 7 (row 2, pad=010).
  - `key_code` goes 0→7 two frames later.
  - One `key_event` pulse; no intermediate 4'hF.
- **Bounce:** key 4 is toggled every other frame for 6 frames → `key_code` stays F and `key_event` never pulses. The key is then held steady → accepted after 2 frames.
- **Priority:** keys 5 and 9 held together → `key_code` = 5. Release 5 only → `key_code` = 9 with one event.
- **Reset mid-operation:** `rst` pulsed during row 2 while key 3 is accepted → outputs return to reset values immediately. Key 3 is re-accepted 2 frames after release.
